// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: stages one stereo pair taken from an AXI-Stream audio
// bus and serializes it as 64-BCLK frames of two left-justified 32-bit slots.
module i2s_tx_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int CHANNEL_ID = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic [7:0]  i_clk_div,
  input  logic        axis_audio_tvalid,
  output logic        axis_audio_tready,
  input  logic [3:0]  axis_audio_tid,
  input  logic [31:0] axis_audio_tdata,
  input  logic        axis_audio_tlast,
  output logic        o_i2s_bclk,
  output logic        o_i2s_lrclk,
  output logic        o_i2s_sdata,
  output logic        o_underflow,
  output logic        o_align_err,
  output logic [15:0] o_underflow_count,
  output logic        o_busy
);

  localparam int PAD_BITS = 32 - DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_EXPECT_L = 2'd0,
    ST_EXPECT_R = 2'd1,
    ST_FULL     = 2'd2
  } stage_state_t;

  stage_state_t stage_state_reg, stage_state_next;
  logic [31:0]  stage_l_reg, stage_l_next;
  logic [31:0]  stage_r_reg, stage_r_next;
  logic         tready_reg, tready_next;
  logic         align_err_reg, align_err_next;

  logic [7:0]   div_reg, div_next;
  logic         bclk_reg, bclk_next;
  logic         lrclk_reg, lrclk_next;
  logic         sdata_reg, sdata_next;
  logic [5:0]   bit_idx_reg, bit_idx_next;
  logic [63:0]  shift_reg, shift_next;
  logic         underflow_reg, underflow_next;
  logic [15:0]  underflow_count_reg, underflow_count_next;
  logic         busy_reg;

  logic [31:0]  beat_slot;
  logic         beat_accept;
  logic         id_match;
  logic         div_tc;
  logic         bclk_fall;
  logic         frame_load;
  logic         unused_tdata_bits;

  // Sample bits sit at the top of the slot; the low PAD_BITS are zero.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_slot
      if (gi >= PAD_BITS) begin : g_data
        assign beat_slot[gi] = axis_audio_tdata[gi - PAD_BITS];
      end else begin : g_pad
        assign beat_slot[gi] = 1'b0;
      end
    end
  endgenerate

  assign unused_tdata_bits = ^axis_audio_tdata;

  assign id_match    = (axis_audio_tid == 4'(CHANNEL_ID));
  assign beat_accept = axis_audio_tvalid & tready_reg;
  assign div_tc      = (div_reg == i_clk_div);
  assign bclk_fall   = i_enable & div_tc & bclk_reg;
  assign frame_load  = bclk_fall & (bit_idx_reg == 6'd0);

  // Staging buffer: collects L then R; a frame load empties it.
  always_comb begin
    stage_state_next = stage_state_reg;
    stage_l_next     = stage_l_reg;
    stage_r_next     = stage_r_reg;
    align_err_next   = 1'b0;
    if (!i_enable) begin
      stage_state_next = ST_EXPECT_L;
      stage_l_next     = '0;
      stage_r_next     = '0;
    end else begin
      if (frame_load && (stage_state_reg == ST_FULL)) begin
        stage_state_next = ST_EXPECT_L;
      end
      if (beat_accept && id_match) begin
        case (stage_state_reg)
          ST_EXPECT_L: begin
            if (!axis_audio_tlast) begin
              stage_l_next     = beat_slot;
              stage_state_next = ST_EXPECT_R;
            end else begin
              align_err_next = 1'b1;
            end
          end
          ST_EXPECT_R: begin
            if (axis_audio_tlast) begin
              stage_r_next     = beat_slot;
              stage_state_next = ST_FULL;
            end else begin
              stage_l_next   = beat_slot;
              align_err_next = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Drops together with the R that fills the buffer, rises one clk after the load.
  assign tready_next = i_enable & (stage_state_reg != ST_FULL) &
                       (stage_state_next != ST_FULL);

  // Bit clock divider and frame serializer; all port changes happen on BCLK falls.
  always_comb begin
    div_next             = div_reg;
    bclk_next            = bclk_reg;
    lrclk_next           = lrclk_reg;
    sdata_next           = sdata_reg;
    bit_idx_next         = bit_idx_reg;
    shift_next           = shift_reg;
    underflow_next       = 1'b0;
    underflow_count_next = underflow_count_reg;
    if (!i_enable) begin
      div_next     = '0;
      bclk_next    = 1'b0;
      lrclk_next   = 1'b0;
      sdata_next   = 1'b0;
      bit_idx_next = 6'd63;
      shift_next   = '0;
    end else if (div_tc) begin
      div_next  = '0;
      bclk_next = ~bclk_reg;
      if (bclk_reg) begin
        bit_idx_next = bit_idx_reg + 6'd1;
        lrclk_next   = bit_idx_next[5];
        if (frame_load) begin
          if (stage_state_reg == ST_FULL) begin
            shift_next = {stage_l_reg, stage_r_reg};
          end else begin
            shift_next     = '0;
            underflow_next = 1'b1;
            if (underflow_count_reg != 16'hFFFF) begin
              underflow_count_next = underflow_count_reg + 16'd1;
            end
          end
        end else begin
          shift_next = {shift_reg[62:0], 1'b0};
        end
        sdata_next = shift_next[63];
      end
    end else begin
      div_next = div_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_state_reg     <= ST_EXPECT_L;
      stage_l_reg         <= '0;
      stage_r_reg         <= '0;
      tready_reg          <= 1'b0;
      align_err_reg       <= 1'b0;
      div_reg             <= '0;
      bclk_reg            <= 1'b0;
      lrclk_reg           <= 1'b0;
      sdata_reg           <= 1'b0;
      bit_idx_reg         <= 6'd63;
      shift_reg           <= '0;
      underflow_reg       <= 1'b0;
      underflow_count_reg <= '0;
      busy_reg            <= 1'b0;
    end else begin
      stage_state_reg     <= stage_state_next;
      stage_l_reg         <= stage_l_next;
      stage_r_reg         <= stage_r_next;
      tready_reg          <= tready_next;
      align_err_reg       <= align_err_next;
      div_reg             <= div_next;
      bclk_reg            <= bclk_next;
      lrclk_reg           <= lrclk_next;
      sdata_reg           <= sdata_next;
      bit_idx_reg         <= bit_idx_next;
      shift_reg           <= shift_next;
      underflow_reg       <= underflow_next;
      underflow_count_reg <= underflow_count_next;
      busy_reg            <= i_enable;
    end
  end

  assign axis_audio_tready = tready_reg;
  assign o_i2s_bclk        = bclk_reg;
  assign o_i2s_lrclk       = lrclk_reg;
  assign o_i2s_sdata       = sdata_reg;
  assign o_underflow       = underflow_reg;
  assign o_align_err       = align_err_reg;
  assign o_underflow_count = underflow_count_reg;
  assign o_busy            = busy_reg;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: rebuilds each I2S frame from the pins and
// compares it, plus pulses, counters and handshake timing, with hand-computed values.
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [7:0]  i_clk_div = 8'd1;
  logic        axis_audio_tvalid = 1'b0;
  logic        axis_audio_tready;
  logic [3:0]  axis_audio_tid = 4'd0;
  logic [31:0] axis_audio_tdata = 32'd0;
  logic        axis_audio_tlast = 1'b0;
  logic        o_i2s_bclk;
  logic        o_i2s_lrclk;
  logic        o_i2s_sdata;
  logic        o_underflow;
  logic        o_align_err;
  logic [15:0] o_underflow_count;
  logic        o_busy;

  always #5 clk = ~clk;

  i2s_tx_serializer #(.DATA_WIDTH(24), .CHANNEL_ID(0)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_enable          (i_enable),
    .i_clk_div         (i_clk_div),
    .axis_audio_tvalid (axis_audio_tvalid),
    .axis_audio_tready (axis_audio_tready),
    .axis_audio_tid    (axis_audio_tid),
    .axis_audio_tdata  (axis_audio_tdata),
    .axis_audio_tlast  (axis_audio_tlast),
    .o_i2s_bclk        (o_i2s_bclk),
    .o_i2s_lrclk       (o_i2s_lrclk),
    .o_i2s_sdata       (o_i2s_sdata),
    .o_underflow       (o_underflow),
    .o_align_err       (o_align_err),
    .o_underflow_count (o_underflow_count),
    .o_busy            (o_busy)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor (sole writer of its variables); the bench uses base snapshots.
  logic [63:0] frames[$];
  logic [63:0] cur = '0;
  int  tb_b = 63;
  bit  started = 0;
  bit  prev_bclk = 0;
  bit  prev_tready = 0;
  bit  have_rise = 0;
  int  last_rise = 0;
  int  bclk_period = 0;
  int  load_cyc = 0;
  int  ready_rise_cyc = 0;
  int  lr_err = 0;
  int  uf_pulses = 0;
  int  align_pulses = 0;

  always @(negedge clk) begin
    if (o_underflow) uf_pulses++;
    if (o_align_err) align_pulses++;
    if (axis_audio_tready && !prev_tready) ready_rise_cyc = cyc;
    prev_tready = axis_audio_tready;
    if (!o_busy) begin
      tb_b = 63;
      started = 0;
      prev_bclk = 0;
      have_rise = 0;
    end else begin
      if (o_i2s_bclk && !prev_bclk) begin
        if (have_rise) bclk_period = cyc - last_rise;
        last_rise = cyc;
        have_rise = 1;
      end
      if (!o_i2s_bclk && prev_bclk) begin
        tb_b = (tb_b + 1) % 64;
        if (o_i2s_lrclk !== (tb_b >= 32)) lr_err++;
        if (tb_b == 0) begin
          if (started) begin
            cur[0] = o_i2s_sdata;
            frames.push_back(cur);
          end
        end else begin
          cur[64 - tb_b] = o_i2s_sdata;
          if (tb_b == 1) begin
            started = 1;
            load_cyc = cyc;
          end
        end
      end
      prev_bclk = o_i2s_bclk;
    end
  end

  int fbase = 0;
  int uf_base = 0;
  int al_base = 0;
  int lr_base = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic mark_mon();
    fbase   = frames.size();
    uf_base = uf_pulses;
    al_base = align_pulses;
    lr_base = lr_err;
  endtask

  task automatic restart(input logic [7:0] div);
    i_enable = 1'b0;
    axis_audio_tvalid = 1'b0;
    rst_n = 1'b0;
    i_clk_div = div;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_enable = 1'b1;
    mark_mon();
  endtask

  task automatic send_beat(input logic [3:0] id, input logic [31:0] d, input logic last);
    int waited;
    waited = 0;
    axis_audio_tvalid = 1'b1;
    axis_audio_tid = id;
    axis_audio_tdata = d;
    axis_audio_tlast = last;
    @(negedge clk);
    while (!axis_audio_tready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 3000) check_eq("tready_timeout", 64'(waited), 64'd0);
    @(posedge clk);
    #1;
    axis_audio_tvalid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int guard;
    guard = 0;
    while (frames.size() < fbase + n && guard < 6000) begin
      @(posedge clk);
      guard++;
    end
    if (frames.size() < fbase + n) check_eq("frame_timeout", 64'(frames.size() - fbase), 64'(n));
    #1;
  endtask

  function automatic logic [63:0] frame_at(input int i);
    if (fbase + i < frames.size()) return frames[fbase + i];
    return 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  initial begin
    logic [31:0] bp_l [4];
    logic [31:0] bp_r [4];
    logic [63:0] bp_exp [4];
    logic [15:0] held;
    int guard;
    bp_l = '{32'h0080_0001, 32'h007F_FFFE, 32'h000F_0F0F, 32'h00C0_0003};
    bp_r = '{32'h0000_0001, 32'h00FF_FFFF, 32'h00F0_F0F0, 32'h003C_3C3C};
    bp_exp = '{64'h8000_0100_0000_0100, 64'h7FFF_FE00_FFFF_FF00,
               64'h0F0F_0F00_F0F0_F000, 64'hC000_0300_3C3C_3C00};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tready", axis_audio_tready, 0);
    check_eq("rst_bclk", o_i2s_bclk, 0);
    check_eq("rst_lrclk", o_i2s_lrclk, 0);
    check_eq("rst_sdata", o_i2s_sdata, 0);
    check_eq("rst_underflow", o_underflow, 0);
    check_eq("rst_align_err", o_align_err, 0);
    check_eq("rst_count", o_underflow_count, 0);
    check_eq("rst_busy", o_busy, 0);

    // Basic frame
    restart(8'd1);
    send_beat(4'd0, 32'h00A5_A5A5, 1'b0);
    send_beat(4'd0, 32'h005A_5A5A, 1'b1);
    @(negedge clk);
    check_eq("basic_tready_drop", axis_audio_tready, 0);
    check_eq("basic_busy", o_busy, 1);
    wait_frames(1);
    check_eq("basic_frame", frame_at(0), 64'hA5A5_A500_5A5A_5A00);
    check_eq("basic_count", o_underflow_count, 0);
    check_eq("basic_bclk_period", 64'(bclk_period), 64'd4);
    check_eq("basic_lrclk_err", 64'(lr_err - lr_base), 0);

    // Underflow
    restart(8'd1);
    wait_frames(3);
    for (int i = 0; i < 3; i++) check_eq($sformatf("uf_frame%0d", i), frame_at(i), 64'd0);
    check_eq("uf_count3", o_underflow_count, 16'd3);
    check_eq("uf_pulses3", 64'(uf_pulses - uf_base), 64'd3);
    repeat (40) @(posedge clk);
    #1;
    send_beat(4'd0, 32'h0012_3456, 1'b0);
    send_beat(4'd0, 32'h00AB_CDEF, 1'b1);
    wait_frames(5);
    check_eq("uf_frame3", frame_at(3), 64'd0);
    check_eq("uf_after_pair", frame_at(4), 64'h1234_5600_ABCD_EF00);
    check_eq("uf_count4", o_underflow_count, 16'd4);

    // Backpressure
    restart(8'd1);
    for (int i = 0; i < 4; i++) begin
      send_beat(4'd0, bp_l[i], 1'b0);
      send_beat(4'd0, bp_r[i], 1'b1);
    end
    wait_frames(4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("bp_frame%0d", i), frame_at(i), bp_exp[i]);
    check_eq("bp_count", o_underflow_count, 0);
    check_eq("bp_uf_pulses", 64'(uf_pulses - uf_base), 0);
    check_eq("bp_tready_rise_lag", 64'(ready_rise_cyc - load_cyc), 64'd1);

    // Filtering and alignment
    restart(8'd3);
    send_beat(4'd3, 32'h0077_7777, 1'b0);
    send_beat(4'd0, 32'h00EE_EEEE, 1'b1);
    send_beat(4'd0, 32'h0011_1111, 1'b0);
    send_beat(4'd0, 32'hFF12_3456, 1'b0);
    send_beat(4'd0, 32'h0065_4321, 1'b1);
    wait_frames(1);
    check_eq("filt_frame", frame_at(0), 64'h1234_5600_6543_2100);
    check_eq("filt_align_pulses", 64'(align_pulses - al_base), 64'd2);
    check_eq("filt_bclk_period", 64'(bclk_period), 64'd8);

    // Disable mid-frame with a half-filled buffer
    send_beat(4'd0, 32'h00AB_CDEF, 1'b0);
    guard = 0;
    while (tb_b != 40 && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check_eq("dis_reached_b40", 64'(tb_b), 64'd40);
    check_eq("dis_lrclk_before", o_i2s_lrclk, 1);
    held = o_underflow_count;
    i_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("dis_bclk", o_i2s_bclk, 0);
    check_eq("dis_lrclk", o_i2s_lrclk, 0);
    check_eq("dis_sdata", o_i2s_sdata, 0);
    check_eq("dis_tready", axis_audio_tready, 0);
    check_eq("dis_busy", o_busy, 0);
    check_eq("dis_count_held", o_underflow_count, held);
    repeat (4) @(posedge clk);
    #1;
    i_enable = 1'b1;
    mark_mon();
    send_beat(4'd0, 32'h0099_9999, 1'b1);
    wait_frames(1);
    check_eq("reen_frame", frame_at(0), 64'd0);
    check_eq("reen_count", o_underflow_count, 16'(held + 16'd1));
    check_eq("reen_align_pulses", 64'(align_pulses - al_base), 64'd1);
    check_eq("reen_lrclk_err", 64'(lr_err - lr_base), 0);

    // Asynchronous reset mid-frame
    repeat (100) @(posedge clk);
    #3;
    check_eq("arst_count_nonzero", 64'(o_underflow_count != 16'd0), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_count", o_underflow_count, 0);
    check_eq("arst_busy", o_busy, 0);
    check_eq("arst_tready", axis_audio_tready, 0);
    check_eq("arst_lrclk_bclk", {o_i2s_lrclk, o_i2s_bclk, o_i2s_sdata}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mark_mon();
    send_beat(4'd0, 32'h00C0_FFEE, 1'b0);
    send_beat(4'd0, 32'h000B_EEF0, 1'b1);
    wait_frames(1);
    check_eq("arst_frame", frame_at(0), 64'hC0FF_EE00_0BEE_F000);
    check_eq("arst_count_after", o_underflow_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
